// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and MEM/WB bundle layout for pipeline stage registers
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam int MEMWB_DATA_W         = 71;
    localparam int MEMWB_MEM_TO_REG_BIT = 70;
    localparam int MEMWB_WB_EN_BIT      = 69;
    localparam int MEMWB_RD_HI          = 68;
    localparam int MEMWB_RD_LO          = 64;
    localparam int MEMWB_ALU_HI         = 63;
    localparam int MEMWB_ALU_LO         = 32;
    localparam int MEMWB_MEM_HI         = 31;
    localparam int MEMWB_MEM_LO         = 0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with optional skid buffer
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = MEMWB_DATA_W,
    parameter int                SKID      = 1,
    parameter logic [DATA_W-1:0] RST_DATA  = '0,
    parameter int                WB_EN_BIT = MEMWB_WB_EN_BIT,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt,
    input  logic              cnt_clr
);

    generate
        if (DATA_W < 1 || WB_EN_BIT >= DATA_W || WB_EN_BIT < -1) begin : g_bad_param
            $error("pipe_stage_reg: illegal DATA_W/WB_EN_BIT combination");
        end
    endgenerate

    localparam bit                WB_MASK_EN = (WB_EN_BIT >= 0) && (WB_EN_BIT < DATA_W);
    localparam int                WB_IDX     = WB_MASK_EN ? WB_EN_BIT : 0;
    localparam logic [DATA_W-1:0] WB_MASK    = WB_MASK_EN ? (DATA_W'(1) << WB_IDX) : '0;

    state_e            r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;

    logic w_out_valid;
    logic w_in_ready;
    logic w_accept;
    logic w_take;

    assign w_out_valid = (r_state != ST_EMPTY);

    // With the skid buffer in_ready is a function of held state only.
    generate
        if (SKID != 0) begin : g_skid
            assign w_in_ready = (r_state != ST_FULL) & rst;
        end else begin : g_pass
            assign w_in_ready = (out_ready | ~w_out_valid) & rst;
        end
    endgenerate

    assign w_accept = in_valid & w_in_ready;
    assign w_take   = w_out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
            r_main  <= RST_DATA;
            r_skid  <= RST_DATA;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main  <= in_data;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_take) begin
                        r_main <= in_data;
                    end else if (w_accept) begin
                        r_skid  <= in_data;
                        r_state <= ST_FULL;
                    end else if (w_take) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_take) begin
                        r_main  <= r_skid;
                        r_state <= ST_ONE;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = w_out_valid ? r_main : (r_main & ~WB_MASK);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_inc   (out_ready & ~w_out_valid),
        .i_clr   (cnt_clr),
        .o_cnt   (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

    localparam int DW = 71;
    localparam int CA = 4;
    localparam int CB = 16;
    localparam int MAX_A = (1 << CA) - 1;
    localparam int MAX_B = (1 << CB) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          a_flush, a_iv, a_ir, a_ov, a_or, a_clr;
    logic [DW-1:0] a_id, a_od;
    logic [CA-1:0] a_cnt;
    logic          b_flush, b_iv, b_ir, b_ov, b_or, b_clr;
    logic [DW-1:0] b_id, b_od;
    logic [CB-1:0] b_cnt;

    pipe_stage_reg #(.DATA_W(DW), .SKID(1), .CNT_W(CA)) u_dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
        .bubble_cnt(a_cnt), .cnt_clr(a_clr)
    );

    pipe_stage_reg #(.DATA_W(DW), .SKID(0), .CNT_W(CB)) u_dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
        .bubble_cnt(b_cnt), .cnt_clr(b_clr)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a FIFO of capacity 2 (skid) or 1 (pass-through), plus upstream sources.
    logic [DW-1:0] qa[$], qb[$], sa[$], sb[$];
    int            ma_cnt = 0, mb_cnt = 0;
    int            vp_a = 0, vp_b = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [95:0] w;
        w = {$urandom, $urandom, $urandom};
        return w[DW-1:0];
    endfunction

    task automatic drive();
        a_iv = (sa.size() > 0) && ($urandom_range(99) < vp_a);
        a_id = (sa.size() > 0) ? sa[0] : rnd();
        b_iv = (sb.size() > 0) && ($urandom_range(99) < vp_b);
        b_id = (sb.size() > 0) ? sb[0] : rnd();
    endtask

    task automatic check_outputs();
        check_eq("a_in_ready", a_ir, rst && (qa.size() < 2));
        check_eq("a_out_valid", a_ov, qa.size() > 0);
        if (qa.size() > 0) check_eq("a_out_data", a_od, qa[0]);
        else               check_eq("a_wb_en_mask", a_od[69], 1'b0);
        check_eq("a_bubble_cnt", a_cnt, ma_cnt);
        check_eq("b_in_ready", b_ir, rst && (b_or || qb.size() == 0));
        check_eq("b_out_valid", b_ov, qb.size() > 0);
        if (qb.size() > 0) check_eq("b_out_data", b_od, qb[0]);
        else               check_eq("b_wb_en_mask", b_od[69], 1'b0);
        check_eq("b_bubble_cnt", b_cnt, mb_cnt);
    endtask

    task automatic tick();
        bit acc_a, tk_a, bub_a, acc_b, tk_b, bub_b;
        @(negedge clk);
        check_outputs();
        acc_a = a_iv && rst && (qa.size() < 2);
        tk_a  = (qa.size() > 0) && a_or;
        bub_a = a_or && (qa.size() == 0);
        acc_b = b_iv && rst && (b_or || qb.size() == 0);
        tk_b  = (qb.size() > 0) && b_or;
        bub_b = b_or && (qb.size() == 0);
        @(posedge clk);
        if (!rst) begin
            qa.delete(); qb.delete();
            ma_cnt = 0; mb_cnt = 0;
        end else begin
            if (acc_a) sa.delete(0);
            if (a_flush) qa.delete();
            else begin
                if (tk_a) qa.delete(0);
                if (acc_a) qa.push_back(a_id);
            end
            if (a_clr) ma_cnt = 0;
            else if (bub_a && ma_cnt < MAX_A) ma_cnt++;
            if (acc_b) sb.delete(0);
            if (b_flush) qb.delete();
            else begin
                if (tk_b) qb.delete(0);
                if (acc_b) qb.push_back(b_id);
            end
            if (b_clr) mb_cnt = 0;
            else if (bub_b && mb_cnt < MAX_B) mb_cnt++;
        end
        #1;
        drive();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst = 1'b0;
        a_flush = 0; a_or = 0; a_clr = 0;
        b_flush = 0; b_or = 0; b_clr = 0;
        sa.push_back(DW'('h55));
        vp_a = 100;
        drive();
        #2;
        check_eq("a_rst_data", a_od, '0);
        check_eq("b_rst_data", b_od, '0);
        repeat (2) tick();

        rst  = 1'b1;
        a_or = 1'b1;
        repeat (3) tick();

        // backpressure fill: A, B accepted, C held upstream
        a_or = 1'b0;
        sa.push_back(DW'('hA)); sa.push_back(DW'('hB)); sa.push_back(DW'('hC));
        drive();
        repeat (4) tick();
        check_eq("a_c_held", sa.size(), 1);
        a_or = 1'b1;
        repeat (5) tick();

        for (int i = 0; i < 100; i++) sa.push_back(DW'(1000 + i));
        drive();
        repeat (104) tick();
        check_eq("a_stream_drained", sa.size(), 0);

        // flush while FULL with a beat offered
        a_or = 1'b0;
        for (int i = 0; i < 3; i++) sa.push_back(rnd());
        drive();
        repeat (3) tick();
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        sa.delete();
        drive();
        check_eq("a_flush_valid", a_ov, 1'b0);
        check_eq("a_flush_ready", a_ir, 1'b1);
        tick();

        // flush in ONE while accepting: the accepted beat is discarded
        sa.push_back(rnd());
        drive();
        tick();
        sa.push_back(rnd());
        a_flush = 1'b1;
        drive();
        tick();
        a_flush = 1'b0;
        tick();

        a_or = 1'b1;
        vp_a = 0;
        drive();
        repeat (20) tick();
        check_eq("a_bubble_sat", a_cnt, MAX_A);
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        check_eq("a_bubble_clr", a_cnt, 0);
        tick();

        // pass-through build with out_ready toggling every cycle
        for (int i = 0; i < 50; i++) sb.push_back(rnd());
        vp_b = 100;
        drive();
        guard = 0;
        while ((sb.size() > 0 || qb.size() > 0) && guard < 400) begin
            b_or = ~b_or;
            tick();
            guard++;
        end
        check_eq("b_drain_50", sb.size() + qb.size(), 0);

        for (int n = 0; n < 400; n++) begin
            if (sa.size() < 3) sa.push_back(rnd());
            if (sb.size() < 3) sb.push_back(rnd());
            vp_a = $urandom_range(100); vp_b = $urandom_range(100);
            a_or = $urandom_range(99) < 60; b_or = $urandom_range(99) < 60;
            a_flush = $urandom_range(99) < 3; b_flush = $urandom_range(99) < 3;
            a_clr = $urandom_range(99) < 3;   b_clr = $urandom_range(99) < 3;
            drive();
            tick();
        end
        a_flush = 0; b_flush = 0; a_clr = 0; b_clr = 0;

        // asynchronous reset while holding entries
        a_or = 1'b0; b_or = 1'b0; vp_a = 100; vp_b = 100;
        sa.push_back(rnd()); sa.push_back(rnd()); sb.push_back(rnd());
        drive();
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        check_eq("a_async_valid", a_ov, 1'b0);
        check_eq("a_async_ready", a_ir, 1'b0);
        check_eq("a_async_data", a_od, '0);
        check_eq("b_async_valid", b_ov, 1'b0);
        qa.delete(); qb.delete(); ma_cnt = 0; mb_cnt = 0;
        tick();
        rst = 1'b1;
        a_or = 1'b1; b_or = 1'b1;
        drive();
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
